spi_led_pwm_ctrl: RTL and testbench
===================================

# spi_led_pwm_ctrl

SPI-commanded, parametrised LED controller driving `N_LED` outputs with per-channel PWM brightness and optional hardware blink. Bytes arrive from the team's `SPI_slave` receiver, instantiated inside this block. A small command FSM decodes one- and two-byte frames, and per-channel PWM engines drive the pins. It sits between the Raspberry Pi SPI link and the board LEDs and supersedes fixed-code on/off LED decoding.

## Interface
- `N_LED`, 3, number of LED channels (1..15)
- `PWM_BITS`, 8, PWM resolution (1..8); duty = `arg[7:8-PWM_BITS]`
- `PRESCALE`, 1, `i_clk` cycles per PWM counter step (≥1)
- `BLINK_DIV`, 2700000, `i_clk` cycles per blink tick (≥1; present only with blink)
- `i_clk`, in, 1, system clock; the only clock
- `i_rst`, in, 1, reset; synchronous and active-high
- `i_sck`, in, 1, SPI clock, passed to `SPI_slave`
- `i_mosi`, in, 1, SPI data, passed to `SPI_slave`
- `i_cs`, in, 1, SPI chip select, active-low
- `o_led`, out, `N_LED`, LED drive, 1 = lit
- `o_busy`, out, 1, high while waiting for an argument byte
- `o_cmd_err`, out, 1, one-cycle pulse on a rejected command

## Operation
- Byte strobe: `SPI_slave` `o_done` high for one `i_clk` cycle, with `o_data` valid.
- Command byte: `[7:4]` opcode, `[3:0]` channel.
- Opcodes:
  - 0x0 OFF: 1 byte, duty ← 0.
  - 0x1 ON: 1 byte, duty ← all-ones.
  - 0x2 SET_DUTY: 2 bytes, duty ← upper `PWM_BITS` bits of the argument.
  - 0x3 BLINK: 2 bytes, blink period ← argument in ticks; 0 disables blink.
  - 0xF ALL_OFF: 1 byte, channel field ignored, every duty ← 0, every blink period ← 0.
- Rejected commands: channel ≥ `N_LED` (except 0xF) or an unknown opcode pulse `o_cmd_err` and make no state change.
  - A two-byte opcode with a bad channel still consumes its argument byte. The error pulses on the command byte.
- FSM states:
  - IDLE: on strobe, decode. A two-byte opcode moves to ARG. A one-byte opcode executes and stays in IDLE.
  - ARG: `o_busy` = 1. On strobe, execute with the latched opcode and channel, then go to IDLE. On `i_cs` deasserted (high), abort to IDLE with no state change and no error.
- `i_cs` is double-flopped into `i_clk` for the abort check.
- PWM:
  - A shared `PWM_BITS` counter advances once every `PRESCALE` cycles and wraps at all-ones.
  - Channel on when `cnt < duty`. Duty all-ones forces the channel fully on. Duty 0 forces it fully off.
- Duty writes go to a per-channel shadow register. Active duty loads from the shadow on the cycle the counter wraps to 0, so updates are glitch-free.
- Blink:
  - Per-channel tick counter. A mask bit toggles each time the counter reaches `period`.
  - `o_led` = pwm & ~mask.
  - Period 0 clears the mask and the counter immediately.
  - A new nonzero period restarts the counter with the mask cleared.
- Reset: `o_led` = 0, `o_busy` = 0, `o_cmd_err` = 0, FSM = IDLE. All duties, shadows, periods, masks and counters are 0.
- Reset takes priority over a simultaneous strobe.

## Timing
- Strobe at cycle N updates the shadow and FSM at N+1. `o_cmd_err` is high during N+1 only.
- Shadow-to-active transfer occurs at the next counter wrap. Worst-case visible latency is 2^`PWM_BITS`·`PRESCALE`+2 cycles.
- `o_led` is registered: one cycle after the compare.
- Abort on `i_cs` takes effect 3 cycles after the `i_cs` rising edge (2 sync + 1 FSM).
- A strobe and an abort in the same cycle: the strobe wins.

## Configuration
- `SPI_LED_BLINK_EN` defined: opcode 0x3, blink counters, the `BLINK_DIV` tick prescaler and masks are built.
- Not defined: opcode 0x3 is an unknown opcode (1 byte, `o_cmd_err`), the mask is constant 0, and `BLINK_DIV` is unused.

## Structure
- Package `spi_led_pkg`: opcode constants (OP_OFF, OP_ON, OP_DUTY, OP_BLINK, OP_ALLOFF) and the FSM state enum (ST_IDLE, ST_ARG).
- Sub-module `spi_led_pwm_channel`, one per LED via generate:
  - shadow and active duty, compare, blink counter and mask;
  - inputs: shared counter, wrap strobe, blink tick, write strobes.
- Top level: `SPI_slave` instance, `i_cs` sync, FSM, shared PWM and blink prescalers.

## Test plan
Bench parameters: `N_LED`=3, `PWM_BITS`=4, `PRESCALE`=1, `BLINK_DIV`=4.

1. Assert `i_rst` for 2 cycles with SPI idle → `o_led`=000, `o_busy`=0, `o_cmd_err`=0.
2. Send 0x11 → after the next wrap `o_led[1]` stays 1 continuously; then 0x01 → `o_led[1]`=0 from the following wrap.
3. Send 0x20, 0x80 → `o_led[0]` high 8 of every 16 cycles, aligned to counter 0; `o_busy` high between the two bytes.
4. Send 0x25, 0x40 → `o_cmd_err` pulses once after the first byte, the second byte is consumed, `o_led` is unchanged and `o_busy` returns to 0.
5. Send 0x22, raise `i_cs`, then send 0x12 in a new frame → `o_busy` drops 3 cycles after `i_cs` rises, and `o_led[2]` goes fully on.
6. With `SPI_LED_BLINK_EN`: 0x12, 0x32, 0x02 → `o_led[2]` toggles every 8 cycles; 0x32, 0x00 → steady on.
   - Without the macro: 0x32 → `o_cmd_err` pulse.

Source files
------------

// File: rtl/spi_led_pkg.sv
// Shared opcode constants and command FSM state encoding for spi_led_pwm_ctrl.
package spi_led_pkg;

  localparam logic [3:0] OP_OFF    = 4'h0;
  localparam logic [3:0] OP_ON     = 4'h1;
  localparam logic [3:0] OP_DUTY   = 4'h2;
  localparam logic [3:0] OP_BLINK  = 4'h3;
  localparam logic [3:0] OP_ALLOFF = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARG  = 1'b1
  } state_t;

endpackage

// File: rtl/SPI_slave.sv
// Mode-0 SPI byte receiver: oversamples sck/mosi/cs in i_clk, MSB first, one-cycle o_done per byte.
module SPI_slave (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic       i_cs,
  output logic       o_done,
  output logic [7:0] o_data
);

  logic [2:0] sck_r;
  logic [1:0] mosi_r;
  logic [1:0] cs_r;
  logic [2:0] bit_r;
  logic [7:0] sh_r;
  logic       done_r;
  logic [7:0] data_r;

  // sck and mosi share sync depth so the sampled bit lines up with the detected rising edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_r  <= 3'b000;
      mosi_r <= 2'b00;
      cs_r   <= 2'b11;
      bit_r  <= 3'd0;
      sh_r   <= 8'd0;
      done_r <= 1'b0;
      data_r <= 8'd0;
    end else begin
      sck_r  <= {sck_r[1:0], i_sck};
      mosi_r <= {mosi_r[0], i_mosi};
      cs_r   <= {cs_r[0], i_cs};
      done_r <= 1'b0;
      if (cs_r[1]) begin
        bit_r <= 3'd0;
      end else if (sck_r[1] && !sck_r[2]) begin
        sh_r  <= {sh_r[6:0], mosi_r[1]};
        bit_r <= bit_r + 3'd1;
        if (bit_r == 3'd7) begin
          done_r <= 1'b1;
          data_r <= {sh_r[6:0], mosi_r[1]};
        end
      end
    end
  end

  assign o_done = done_r;
  assign o_data = data_r;

endmodule

// File: rtl/spi_led_pwm_channel.sv
// One LED channel: shadow/active duty, PWM compare, optional blink mask (SPI_LED_BLINK_EN).
module spi_led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                wrap,
  input  logic                duty_we,
  input  logic [PWM_BITS-1:0] duty_val,
`ifdef SPI_LED_BLINK_EN
  input  logic                tick,
  input  logic                blink_we,
  input  logic [7:0]          period_val,
`endif
  output logic                led
);

  logic [PWM_BITS-1:0] shadow_r;
  logic [PWM_BITS-1:0] active_r;
  logic                pwm_s;
  logic                mask_s;
  logic                led_r;

  // Active duty only changes at the counter wrap so a period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= '0;
      active_r <= '0;
    end else begin
      if (duty_we) shadow_r <= duty_val;
      if (wrap) active_r <= shadow_r;
    end
  end

  always_comb begin
    pwm_s = 1'b0;
    if (active_r == '1) begin
      pwm_s = 1'b1;
    end else if (active_r == '0) begin
      pwm_s = 1'b0;
    end else begin
      pwm_s = (cnt < active_r);
    end
  end

`ifdef SPI_LED_BLINK_EN
  logic [7:0] period_r;
  logic [7:0] bcnt_r;
  logic       mask_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_r <= 8'd0;
      bcnt_r   <= 8'd0;
      mask_r   <= 1'b0;
    end else if (blink_we) begin
      period_r <= period_val;
      bcnt_r   <= 8'd0;
      mask_r   <= 1'b0;
    end else if (period_r == 8'd0) begin
      bcnt_r <= 8'd0;
      mask_r <= 1'b0;
    end else if (tick) begin
      if (bcnt_r + 8'd1 == period_r) begin
        bcnt_r <= 8'd0;
        mask_r <= ~mask_r;
      end else begin
        bcnt_r <= bcnt_r + 8'd1;
      end
    end
  end

  assign mask_s = mask_r;
`else
  assign mask_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) led_r <= 1'b0;
    else     led_r <= pwm_s & ~mask_s;
  end

  assign led = led_r;

endmodule

// File: rtl/spi_led_pwm_ctrl.sv
// SPI-commanded multi-channel PWM LED controller; blink support built when SPI_LED_BLINK_EN is defined.
module spi_led_pwm_ctrl
  import spi_led_pkg::*;
#(
  parameter int N_LED     = 3,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 1,
  parameter int BLINK_DIV = 2700000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sck,
  input  logic             i_mosi,
  input  logic             i_cs,
  output logic [N_LED-1:0] o_led,
  output logic             o_busy,
  output logic             o_cmd_err
);

  localparam int         PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [3:0] N_LED_C = 4'(N_LED);

  logic       rx_done;
  logic [7:0] rx_data;

  SPI_slave u_spi (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sck  (i_sck),
    .i_mosi (i_mosi),
    .i_cs   (i_cs),
    .o_done (rx_done),
    .o_data (rx_data)
  );

  logic          cs_meta_r, cs_sync_r;
  state_t        state_r, state_n;
  logic [3:0]    ch_r;
  logic          bad_r;
  logic          err_r;
  logic [3:0]    op_s, ch_s;
  logic          ch_ok_s, latch_s, err_s, do_duty_s, all_off_s;
  logic [3:0]    exec_ch_s;
  logic [7:0]    exec_val_s;
  logic [PW-1:0] pre_r;
  logic          step_s, wrap_s;
  logic [PWM_BITS-1:0] cnt_r;
`ifdef SPI_LED_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bdiv_r;
  logic          tick_s, blink_r, is_blink_s, do_blink_s;
`endif

  assign op_s    = rx_data[7:4];
  assign ch_s    = rx_data[3:0];
  assign ch_ok_s = (ch_s < N_LED_C);

  // A strobe in ARG takes precedence over a simultaneous abort
  always_comb begin
    state_n    = state_r;
    latch_s    = 1'b0;
    err_s      = 1'b0;
    do_duty_s  = 1'b0;
    all_off_s  = 1'b0;
    exec_ch_s  = ch_s;
    exec_val_s = 8'd0;
`ifdef SPI_LED_BLINK_EN
    is_blink_s = 1'b0;
    do_blink_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rx_done) begin
          case (op_s)
            OP_OFF: begin
              do_duty_s = ch_ok_s;
              err_s     = ~ch_ok_s;
            end
            OP_ON: begin
              do_duty_s  = ch_ok_s;
              err_s      = ~ch_ok_s;
              exec_val_s = 8'hFF;
            end
            OP_DUTY: begin
              state_n = ST_ARG;
              latch_s = 1'b1;
              err_s   = ~ch_ok_s;
            end
`ifdef SPI_LED_BLINK_EN
            OP_BLINK: begin
              state_n    = ST_ARG;
              latch_s    = 1'b1;
              is_blink_s = 1'b1;
              err_s      = ~ch_ok_s;
            end
`endif
            OP_ALLOFF: all_off_s = 1'b1;
            default:   err_s = 1'b1;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ARG: begin
        exec_ch_s = ch_r;
        if (rx_done) begin
          state_n    = ST_IDLE;
          exec_val_s = rx_data;
`ifdef SPI_LED_BLINK_EN
          do_duty_s  = ~bad_r & ~blink_r;
          do_blink_s = ~bad_r & blink_r;
`else
          do_duty_s  = ~bad_r;
`endif
        end else if (cs_sync_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ARG;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_meta_r <= 1'b1;
      cs_sync_r <= 1'b1;
      state_r   <= ST_IDLE;
      ch_r      <= 4'd0;
      bad_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cs_meta_r <= i_cs;
      cs_sync_r <= cs_meta_r;
      state_r   <= state_n;
      err_r     <= err_s;
      if (latch_s) begin
        ch_r  <= ch_s;
        bad_r <= ~ch_ok_s;
      end
    end
  end

`ifdef SPI_LED_BLINK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)        blink_r <= 1'b0;
    else if (latch_s) blink_r <= is_blink_s;
  end

  assign tick_s = (bdiv_r == BW'(BLINK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)       bdiv_r <= '0;
    else if (tick_s) bdiv_r <= '0;
    else             bdiv_r <= bdiv_r + BW'(1);
  end
`endif

  assign step_s = (pre_r == PW'(PRESCALE - 1));
  assign wrap_s = step_s && (cnt_r == '1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_r <= '0;
      cnt_r <= '0;
    end else begin
      pre_r <= step_s ? '0 : pre_r + PW'(1);
      if (step_s) cnt_r <= cnt_r + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    spi_led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (i_clk),
      .rst        (i_rst),
      .cnt        (cnt_r),
      .wrap       (wrap_s),
      .duty_we    (all_off_s | (do_duty_s & (exec_ch_s == 4'(i)))),
      .duty_val   (exec_val_s[7 -: PWM_BITS]),
`ifdef SPI_LED_BLINK_EN
      .tick       (tick_s),
      .blink_we   (all_off_s | (do_blink_s & (exec_ch_s == 4'(i)))),
      .period_val (exec_val_s),
`endif
      .led        (o_led[i])
    );
  end

  assign o_busy    = (state_r == ST_ARG);
  assign o_cmd_err = err_r;

endmodule

// File: tb/tb_spi_led_pwm_ctrl.sv
// Directed bench for spi_led_pwm_ctrl (N_LED=3, PWM_BITS=4, PRESCALE=1, BLINK_DIV=4).
module tb_spi_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic [2:0] led;
  logic       busy;
  logic       cmd_err;
  logic [3:0] model_cnt;
  int         errors = 0;
  int         checks = 0;
  int         err_pulses = 0;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    int         exp_err;
    int         exp0;
    int         exp1;
    int         exp2;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  spi_led_pwm_ctrl #(.N_LED(3), .PWM_BITS(4), .PRESCALE(1), .BLINK_DIV(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sck     (sck),
    .i_mosi    (mosi),
    .i_cs      (cs),
    .o_led     (led),
    .o_busy    (busy),
    .o_cmd_err (cmd_err)
  );

  // Reference PWM counter: zero in reset, one step per clock afterwards
  always @(posedge clk) begin
    if (rst) model_cnt <= 4'd0;
    else     model_cnt <= model_cnt + 4'd1;
  end

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int n);
    cs = 1'b0;
    tick(4);
    send_byte(b0);
    if (n == 2) send_byte(b1);
    tick(2);
    cs = 1'b1;
    tick(6);
  endtask

  task automatic measure(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (16) begin
      @(negedge clk);
      c0 += int'(led[0]);
      c1 += int'(led[1]);
      c2 += int'(led[2]);
    end
  endtask

  initial begin
    int c0, c1, c2, base, cnt, bad;
    logic [3:0] prev;

    vecs[0]  = '{8'hF0, 8'h00, 1, 0, 0, 0, 0};
    vecs[1]  = '{8'h11, 8'h00, 1, 0, 0, 16, 0};
    vecs[2]  = '{8'h01, 8'h00, 1, 0, 0, 0, 0};
    vecs[3]  = '{8'h21, 8'h30, 2, 0, 0, 3, 0};
    vecs[4]  = '{8'h22, 8'hF0, 2, 0, 0, 3, 16};
    vecs[5]  = '{8'h22, 8'h10, 2, 0, 0, 3, 1};
    vecs[6]  = '{8'h12, 8'h00, 1, 0, 0, 3, 16};
    vecs[7]  = '{8'h25, 8'h40, 2, 1, 0, 3, 16};
    vecs[8]  = '{8'h50, 8'h00, 1, 1, 0, 3, 16};
    vecs[9]  = '{8'h03, 8'h00, 1, 1, 0, 3, 16};
    vecs[10] = '{8'h20, 8'hA5, 2, 0, 10, 3, 16};
`ifdef SPI_LED_BLINK_EN
    vecs[11] = '{8'h32, 8'h02, 2, 0, 10, 3, 8};
    vecs[12] = '{8'h32, 8'h00, 2, 0, 10, 3, 16};
`else
    vecs[11] = '{8'h32, 8'h00, 1, 1, 10, 3, 16};
    vecs[12] = '{8'h40, 8'h00, 1, 1, 10, 3, 16};
`endif
    vecs[13] = '{8'hF5, 8'h00, 1, 0, 0, 0, 0};

    tick(2);
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(cmd_err), 0);
    rst = 1'b0;
    tick(4);

    // Duty 8 on channel 0, busy between command and argument, phase vs counter
    base = err_pulses;
    cs = 1'b0;
    tick(4);
    send_byte(8'h20);
    tick(4);
    check("busy_between_bytes", int'(busy), 1);
    send_byte(8'h80);
    tick(2);
    cs = 1'b1;
    tick(6);
    check("busy_after_arg", int'(busy), 0);
    tick(40);
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      prev = model_cnt - 4'd1;
      if (led[0] != (prev < 4'd8)) bad++;
    end
    check("duty8_alignment", bad, 0);
    check("duty8_no_err", err_pulses - base, 0);

    // Abort an argument wait by raising cs, then a fresh frame
    base = err_pulses;
    cs = 1'b0;
    tick(4);
    send_byte(8'h22);
    tick(4);
    check("abort_busy_before", int'(busy), 1);
    cs = 1'b1;
    cnt = 0;
    while (busy && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort_latency", cnt, 3);
    tick(6);
    frame(8'h12, 8'h00, 1);
    tick(40);
    measure(c0, c1, c2);
    check("abort_then_on_ch2", c2, 16);
    check("abort_then_ch0", c0, 8);
    check("abort_no_err", err_pulses - base, 0);

    for (int v = 0; v < 14; v++) begin
      base = err_pulses;
      frame(vecs[v].b0, vecs[v].b1, vecs[v].nbytes);
      tick(40);
      measure(c0, c1, c2);
      check($sformatf("vec%0d_ch0", v), c0, vecs[v].exp0);
      check($sformatf("vec%0d_ch1", v), c1, vecs[v].exp1);
      check($sformatf("vec%0d_ch2", v), c2, vecs[v].exp2);
      check($sformatf("vec%0d_err", v), err_pulses - base, vecs[v].exp_err);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
